// File: rtl/data_beat_serializer_64x16_pkg.sv
// Shared constants and FSM state encodings for the 64-bit to 4x16-bit beat serializer.
package data_beat_serializer_64x16_pkg;

    localparam int WORD_W  = 16;
    localparam int BEATS   = 4;
    localparam int SUM_W   = 8;
    localparam int FRAME_W = 64;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

endpackage

// File: rtl/data_beat_serializer_64x16_ones_count.sv
// Combinational population count of one 16-bit beat.
module ones_count_16
    import data_beat_serializer_64x16_pkg::*;
(
    input  logic [WORD_W-1:0] beat,
    output logic [CNT_W-1:0]  count
);

    // Sum the set bits of the beat
    always_comb begin
        count = 5'd0;
        for (int i = 0; i < WORD_W; i++) begin
            count = count + {4'd0, beat[i]};
        end
    end

endmodule

// File: rtl/data_beat_serializer_64x16.sv
// Splits a 64-bit frame into four 16-bit beats and computes the golden weighted
// ones-sum (popcount(beat) << beat_idx) that the downstream accumulator should reach.
module data_beat_serializer_64x16 #(
    parameter int WORD_W = 16,
    parameter int BEATS  = 4,
    parameter int SUM_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BEATS*WORD_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WORD_W-1:0]         data_bits,
    output logic                      out_valid,
    output logic [1:0]                beat_idx,
    output logic                      frame_start,
    output logic                      frame_last,
    output logic [SUM_W-1:0]          expected_sum,
    output logic                      expected_valid
);
    import data_beat_serializer_64x16_pkg::*;

    logic [0:0]         state_r;
    logic [FRAME_W-1:0] hold_r;
    logic [SUM_W-1:0]   acc_r;

    logic               accept_s;
    logic               last_beat_s;
    logic [1:0]         next_idx_s;
    logic [WORD_W-1:0]  beat_sel_s;
    logic [CNT_W-1:0]   pop_s;
    logic [SUM_W-1:0]   weighted_s;
    logic [SUM_W-1:0]   acc_sum_s;

    ones_count_16 u_ones_count (
        .beat  (data_bits),
        .count (pop_s)
    );

    // Ready depends only on state and beat index so it never loops back through in_valid
    assign in_ready = (state_r == IDLE) || (beat_idx == 2'd3);

    // Next-beat selection and weighted accumulation of the beat currently on data_bits
    always_comb begin
        accept_s    = in_valid && in_ready;
        last_beat_s = out_valid && (beat_idx == 2'd3);
        next_idx_s  = beat_idx + 2'd1;
        case (next_idx_s)
            2'd1:    beat_sel_s = hold_r[31:16];
            2'd2:    beat_sel_s = hold_r[47:32];
            2'd3:    beat_sel_s = hold_r[63:48];
            default: beat_sel_s = hold_r[15:0];
        endcase
        weighted_s = {3'b000, pop_s} << beat_idx;
        // Beat 0 restarts the sum, so a back-to-back frame never sees the old total
        acc_sum_s  = ((beat_idx == 2'd0) ? 8'd0 : acc_r) + weighted_s;
    end

    // Beat sequencing, holding register and golden-sum registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            hold_r         <= 64'd0;
            acc_r          <= 8'd0;
            data_bits      <= 16'd0;
            out_valid      <= 1'b0;
            beat_idx       <= 2'd0;
            frame_start    <= 1'b0;
            frame_last     <= 1'b0;
            expected_sum   <= 8'd0;
            expected_valid <= 1'b0;
        end else begin
            expected_valid <= 1'b0;
            if (out_valid) begin
                acc_r <= acc_sum_s;
            end
            if (last_beat_s) begin
                expected_sum   <= acc_sum_s;
                expected_valid <= 1'b1;
            end

            if (accept_s) begin
                state_r     <= SEND;
                hold_r      <= in_data;
                data_bits   <= in_data[15:0];
                beat_idx    <= 2'd0;
                out_valid   <= 1'b1;
                frame_start <= 1'b1;
                frame_last  <= 1'b0;
            end else if ((state_r == SEND) && (beat_idx != 2'd3)) begin
                data_bits   <= beat_sel_s;
                beat_idx    <= next_idx_s;
                frame_start <= 1'b0;
                frame_last  <= (next_idx_s == 2'd3);
            end else begin
                // Idle drives a zero beat so the downstream accumulator adds nothing
                state_r     <= IDLE;
                data_bits   <= 16'd0;
                out_valid   <= 1'b0;
                beat_idx    <= 2'd0;
                frame_start <= 1'b0;
                frame_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_beat_serializer_64x16.sv
// Directed bench for data_beat_serializer_64x16 with hand-computed expected values.
module tb_data_beat_serializer_64x16;

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_bits;
    logic        out_valid;
    logic [1:0]  beat_idx;
    logic        frame_start;
    logic        frame_last;
    logic [7:0]  expected_sum;
    logic        expected_valid;

    int checks;
    int errors;

    data_beat_serializer_64x16 dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_bits      (data_bits),
        .out_valid      (out_valid),
        .beat_idx       (beat_idx),
        .frame_start    (frame_start),
        .frame_last     (frame_last),
        .expected_sum   (expected_sum),
        .expected_valid (expected_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({out_valid, beat_idx, frame_start, frame_last, data_bits, expected_sum, expected_valid, in_ready}
                !== {1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got ov=%b idx=%0d fs=%b fl=%b d=%h es=%0d ev=%b rdy=%b, need all 0 and rdy=1",
                         c, out_valid, beat_idx, frame_start, frame_last, data_bits, expected_sum, expected_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b ov=%b, need rdy=1 ov=0", in_ready, out_valid);
        end
    endtask

    // Sends one frame from IDLE, checks every beat and the completion pulse.
    // With stall set, a junk frame is offered during beat 1 and must be ignored.
    task automatic send_frame(input logic [63:0] data, input logic [7:0] exp_sum, input bit stall);
        logic [1:0] kk;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b, need 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            if (stall && k == 2) in_valid = 1'b0;
            checks++;
            if ({out_valid, beat_idx, frame_start, frame_last, in_ready, expected_valid, data_bits}
                !== {1'b1, kk, (k == 0), (k == 3), (k == 3), 1'b0, data[16*k +: 16]}) begin
                errors++;
                $display("FAIL beat%0d of %h: got ov=%b idx=%0d fs=%b fl=%b rdy=%b ev=%b d=%h, need ov=1 idx=%0d fs=%b fl=%b rdy=%b ev=0 d=%h",
                         k, data, out_valid, beat_idx, frame_start, frame_last, in_ready, expected_valid, data_bits,
                         k, (k == 0), (k == 3), (k == 3), data[16*k +: 16]);
            end
            if (stall && k == 1) begin
                in_valid = 1'b1;
                in_data  = 64'h1234_5678_9ABC_DEF0;
            end
            tick();
        end
        checks++;
        if ({expected_valid, expected_sum, out_valid, beat_idx, data_bits, frame_last}
            !== {1'b1, exp_sum, 1'b0, 2'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL done %h: got ev=%b es=%0d ov=%b idx=%0d d=%h fl=%b, need ev=1 es=%0d ov=0 idx=0 d=0 fl=0",
                     data, expected_valid, expected_sum, out_valid, beat_idx, data_bits, frame_last, exp_sum);
        end
        tick();
        checks++;
        if ({expected_valid, expected_sum, out_valid} !== {1'b0, exp_sum, 1'b0}) begin
            errors++;
            $display("FAIL hold %h: got ev=%b es=%0d ov=%b, need ev=0 es=%0d ov=0",
                     data, expected_valid, expected_sum, out_valid, exp_sum);
        end
    endtask

    task automatic test_all_ones();
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'd240, 1'b0);
    endtask

    task automatic test_weights();
        send_frame(64'h0000_0000_0000_0001, 8'd1, 1'b0);
        send_frame(64'h0001_0000_0000_0000, 8'd8, 1'b0);
        send_frame(64'h0000_0003_0000_0000, 8'd8, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] f;
        logic [1:0]  kk;
        in_valid = 1'b1;
        in_data  = 64'h0000_0000_0000_000F;
        tick();
        in_data  = 64'hFFFF_0000_0000_0000;
        for (int k = 0; k < 8; k++) begin
            kk = 2'(k % 4);
            f  = (k < 4) ? 64'h0000_0000_0000_000F : 64'hFFFF_0000_0000_0000;
            if (k == 4) in_valid = 1'b0;
            checks++;
            if ({out_valid, beat_idx, frame_start, frame_last, in_ready, data_bits}
                !== {1'b1, kk, (kk == 2'd0), (kk == 2'd3), (kk == 2'd3), f[16*(k % 4) +: 16]}) begin
                errors++;
                $display("FAIL b2b cyc%0d: got ov=%b idx=%0d fs=%b fl=%b rdy=%b d=%h, need ov=1 idx=%0d d=%h",
                         k, out_valid, beat_idx, frame_start, frame_last, in_ready, data_bits, kk, f[16*(k % 4) +: 16]);
            end
            checks++;
            if (expected_valid !== (k == 4) || (k == 4 && expected_sum !== 8'd4)) begin
                errors++;
                $display("FAIL b2b_sum1 cyc%0d: got ev=%b es=%0d, need ev=%b es=4", k, expected_valid, expected_sum, (k == 4));
            end
            tick();
        end
        checks++;
        if ({expected_valid, expected_sum, out_valid, in_ready} !== {1'b1, 8'd128, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_sum2: got ev=%b es=%0d ov=%b rdy=%b, need ev=1 es=128 ov=0 rdy=1",
                     expected_valid, expected_sum, out_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_stall();
        // popcounts 8,6,4,2 weighted 1,2,4,8 -> 8+12+16+16 = 52
        send_frame(64'h0101_0303_0707_0F0F, 8'd52, 1'b1);
        tick();
        checks++;
        if ({out_valid, expected_valid, expected_sum} !== {1'b0, 1'b0, 8'd52}) begin
            errors++;
            $display("FAIL stall_no_extra: got ov=%b ev=%b es=%0d, need ov=0 ev=0 es=52", out_valid, expected_valid, expected_sum);
        end
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, beat_idx} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL mid_pre: got ov=%b idx=%0d, need ov=1 idx=2", out_valid, beat_idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, beat_idx, frame_start, frame_last, data_bits, expected_sum, expected_valid, in_ready}
            !== {1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_async: got ov=%b idx=%0d d=%h es=%0d ev=%b rdy=%b, need all 0 and rdy=1",
                     out_valid, beat_idx, data_bits, expected_sum, expected_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({expected_valid, expected_sum, out_valid} !== {1'b0, 8'd0, 1'b0}) begin
                errors++;
                $display("FAIL mid_no_pulse cyc%0d: got ev=%b es=%0d ov=%b, need 0 0 0", c, expected_valid, expected_sum, out_valid);
            end
        end
        send_frame(64'h0000_0000_0000_00FF, 8'd8, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 64'd0;
        test_reset();
        test_all_ones();
        test_weights();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
